ram_array: RTL

- Parametrised successor to the 4-word RAM: WIDTH-bit words, DEPTH entries, req/ready handshake, registered read port with a valid flag.
- Built-in zero-initialisation sweep after reset and on a clear request.
- Sits between the CPU datapath (address/data buses) and the control unit, which issues requests and waits on ready.

---
 rtl/ram_array_pkg.sv | 13 +
 rtl/ram_init_ctrl.sv | 60 ++++++
 rtl/ram_array.sv | 94 +++++++++
 3 files changed

// File: rtl/ram_array_pkg.sv
// Shared definitions for the parametrised word RAM: default geometry and
// the two-state controller encoding used by ram_init_ctrl and ram_array.
package ram_array_pkg;

    localparam int RAM_WORDSIZE = 8;
    localparam int RAM_DEPTH    = 16;

    typedef enum logic {
        RAM_ST_INIT = 1'b0,
        RAM_ST_RUN  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_init_ctrl.sv
// Init/run controller: walks a counter over every word after reset or a
// clear request and exposes it as a zero-write port for the RAM.
module ram_init_ctrl
    import ram_array_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          clear,
    output ram_state_e    state,
    output logic          init_we,
    output logic [AW-1:0] init_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    ram_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= RAM_ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RAM_ST_INIT: begin
                // clear has no effect here: a sweep in progress always runs to the end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RAM_ST_RUN;
                    cnt_d   = '0;
                end
            end
            RAM_ST_RUN: begin
                if (clear) begin
                    state_d = RAM_ST_INIT;
                end
            end
            default: begin
                state_d = RAM_ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign state     = state_q;
    assign init_we   = (state_q == RAM_ST_INIT);
    assign init_addr = cnt_q;

endmodule

// File: rtl/ram_array.sv
// Single-port word RAM with req/ready handshake, one-cycle registered read,
// out-of-range flagging and a self-clearing zero sweep.
module ram_array
    import ram_array_pkg::*;
#(
    parameter int  WIDTH = RAM_WORDSIZE,
    parameter int  DEPTH = RAM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic             ready,
    output logic             rvalid,
    output logic [WIDTH-1:0] data_out,
    output logic             addr_err,
    output logic             init_busy
);

    ram_state_e    state;
    logic          init_we;
    logic [AW-1:0] init_addr;

    ram_init_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_ctrl (
        .clk       (clk),
        .clr       (clr),
        .clear     (clear),
        .state     (state),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    logic [WIDTH-1:0] mem [DEPTH];
    logic             accept;
    logic             in_range;
    logic             rd_en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] ram_q;
    logic             rvalid_q;
    logic             addr_err_q;
    logic             zero_q;

    assign ready    = (state == RAM_ST_RUN) && !clear;
    assign accept   = req && ready;
    assign in_range = ({1'b0, addr} < (AW + 1)'(DEPTH));
    assign rd_en    = accept && !we && in_range;

    // accept is only possible in RUN, so the sweep and user writes never collide
    assign wr_en   = init_we || (accept && we && in_range);
    assign wr_addr = init_we ? init_addr : addr;
    assign wr_data = init_we ? '0 : data_in;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_q <= mem[addr];
        end
    end

    // zero_q masks the unreset RAM output register after reset and on out-of-range reads
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            rvalid_q   <= accept && !we;
            addr_err_q <= accept && !in_range;
            if (accept && !we) begin
                zero_q <= !in_range;
            end
        end
    end

    assign rvalid    = rvalid_q;
    assign addr_err  = addr_err_q;
    assign data_out  = zero_q ? '0 : ram_q;
    assign init_busy = (state == RAM_ST_INIT);

endmodule
